// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encoding,
// 50 MHz default timing constants and the counter-width helper.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ARMING    = 2'b01,
        HELD      = 2'b10,
        RELEASING = 2'b11
    } key_state_e;

    localparam int DEF_DEBOUNCE_CYC  = 500000;
    localparam int DEF_REPEAT_DELAY  = 25000000;
    localparam int DEF_REPEAT_PERIOD = 5000000;

    // Bits needed to hold (largest timing parameter - 1).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        m = (b > m) ? b : m;
        m = (c > m) ? c : m;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchronizer, debounce FSM and counter, raw pulse and level.
// KEY_AUTO_REPEAT_EN adds a hold-to-repeat timer.
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic iCLK,
    input  logic iRESETn,
    input  logic key_n,
    output logic pulse_s,
    output logic lvl_s
);

    localparam int CW = cnt_width(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    // Compare against the pre-increment value so DEBOUNCE_CYC samples qualify.
    localparam logic [CW-1:0] ARM_LAST = CW'(DEBOUNCE_CYC - 2);

    logic          sync1_r, sync2_r;
    logic          key_s;
    key_state_e    state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic          qual_s, rel_done_s, rpt_fire_s;

    // Two-flop synchronizer, reset to the released level
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
        end
    end

    assign key_s = ~sync2_r;

    // FSM state and debounce counter registers
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (key_s) state_nxt_s = ARMING;
                else       state_nxt_s = IDLE;
            end
            ARMING: begin
                if (!key_s) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == ARM_LAST) begin
                    state_nxt_s = HELD;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            HELD: begin
                cnt_nxt_s = CNT_ZERO;
                if (!key_s) state_nxt_s = RELEASING;
                else        state_nxt_s = HELD;
            end
            RELEASING: begin
                if (key_s) begin
                    state_nxt_s = HELD;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == ARM_LAST) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Outputs: level follows the next state so it lines up with the registered pulse
    always_comb begin
        qual_s     = (state_r == ARMING) && key_s && (cnt_r == ARM_LAST);
        rel_done_s = (state_r == RELEASING) && !key_s && (cnt_r == ARM_LAST);
        case (state_nxt_s)
            HELD, RELEASING: lvl_s = 1'b1;
            default:         lvl_s = 1'b0;
        endcase
        pulse_s = qual_s | rpt_fire_s;
    end

`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [CW-1:0] RPT_DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RPT_PER_LAST = CW'(REPEAT_PERIOD - 1);

    logic [CW-1:0] rpt_r;
    logic          rpt_first_r, rpt_run_s, rpt_hit_s;

    // Repeat decode; no repeat once the release has qualified
    always_comb begin
        rpt_run_s = (state_r == HELD) || (state_r == RELEASING);
        if (rpt_first_r) rpt_hit_s = (rpt_r == RPT_DLY_LAST);
        else             rpt_hit_s = (rpt_r == RPT_PER_LAST);
        rpt_fire_s = rpt_run_s && rpt_hit_s && !rel_done_s;
    end

    // Repeat timer: idle outside HELD/RELEASING, reloads after every repeat
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            rpt_r       <= CNT_ZERO;
            rpt_first_r <= 1'b1;
        end else if (!rpt_run_s) begin
            rpt_r       <= CNT_ZERO;
            rpt_first_r <= 1'b1;
        end else if (rpt_hit_s) begin
            rpt_r       <= CNT_ZERO;
            rpt_first_r <= 1'b0;
        end else begin
            rpt_r       <= rpt_r + CNT_ONE;
        end
    end
`else
    assign rpt_fire_s = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Debounced up/down step pulses and levels for the LED counter; up wins ties.
// Define KEY_AUTO_REPEAT_EN to enable hold-to-repeat in both channels.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic iCLK,
    input  logic iRESETn,
    input  logic iUP,
    input  logic iDOWN,
    output logic oUP,
    output logic oDOWN,
    output logic oUP_LVL,
    output logic oDOWN_LVL
);

    logic up_pulse_s, up_lvl_s, dn_pulse_s, dn_lvl_s;
    logic up_r, dn_r, up_lvl_r, dn_lvl_r;

    key_channel #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_up (
        .iCLK   (iCLK),
        .iRESETn(iRESETn),
        .key_n  (iUP),
        .pulse_s(up_pulse_s),
        .lvl_s  (up_lvl_s)
    );

    key_channel #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_down (
        .iCLK   (iCLK),
        .iRESETn(iRESETn),
        .key_n  (iDOWN),
        .pulse_s(dn_pulse_s),
        .lvl_s  (dn_lvl_s)
    );

    // Output registers; a coincident down pulse is dropped in favour of up
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            up_r     <= 1'b0;
            dn_r     <= 1'b0;
            up_lvl_r <= 1'b0;
            dn_lvl_r <= 1'b0;
        end else begin
            up_r     <= up_pulse_s;
            dn_r     <= dn_pulse_s & ~up_pulse_s;
            up_lvl_r <= up_lvl_s;
            dn_lvl_r <= dn_lvl_s;
        end
    end

    assign oUP       = up_r;
    assign oDOWN     = dn_r;
    assign oUP_LVL   = up_lvl_r;
    assign oDOWN_LVL = dn_lvl_r;

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input-side conditioner for the LED up/down counter.
- Takes the raw active-low push-buttons iUP and iDOWN and synchronizes and debounces them.
- Produces clean one-cycle active-high step pulses, plus debounced levels, for the counter FSM.
- Runs on the fast system clock, not on the divided clock.

Parameters:
- DEBOUNCE_CYC, 500000: consecutive stable cycles required to accept a press or release (10 ms at 50 MHz); must be ≥2.
- REPEAT_DELAY, 25000000: cycles a key must stay held after the first pulse before auto-repeat starts (only with the macro); must be ≥2.
- REPEAT_PERIOD, 5000000: cycles between auto-repeat pulses (only with the macro); must be ≥2.

Ports:
- iCLK, input, 1: system clock.
- iRESETn, input, 1: asynchronous reset, active-low.
- iUP, input, 1: raw up button, active-low, asynchronous to iCLK.
- iDOWN, input, 1: raw down button, active-low, asynchronous to iCLK.
- oUP, output, 1: one-cycle active-high up-step pulse.
- oDOWN, output, 1: one-cycle active-high down-step pulse.
- oUP_LVL, output, 1: debounced up level, 1 = held.
- oDOWN_LVL, output, 1: debounced down level, 1 = held.

Behaviour:
- Reset (async assert, sync deassert at the iCLK edge):
  - synchronizer flops = 1 (released);
  - all FSMs go to IDLE and all counters clear;
  - oUP, oDOWN, oUP_LVL and oDOWN_LVL = 0.
  - Reset mid-press discards all progress. A key still held after reset must be re-qualified through ARMING.
- Synchronizer: each key passes through 2 flops; s = inverted second flop, so 1 = pressed.
- Per-key FSM, with counter cnt of width $clog2 of the largest parameter:
  - IDLE: cnt = 0. If s = 1, go to ARMING.
  - ARMING: if s = 0, go to IDLE with cnt = 0 (glitch rejected). Else cnt increments. When cnt == DEBOUNCE_CYC-1, go to HELD and assert the pulse for exactly 1 cycle.
  - HELD: LVL = 1. If s = 0, go to RELEASING with cnt = 0.
  - RELEASING: LVL stays 1. If s = 1, return to HELD with no new pulse and the repeat timer preserved. Else cnt increments. When cnt == DEBOUNCE_CYC-1, go to IDLE and LVL = 0. Release never produces a pulse.
- Latency: the pulse appears 2 (synchronizer) + DEBOUNCE_CYC cycles after the raw falling edge, with the raw input held low throughout.
- Simultaneous events: if the up and down pulses would fire in the same cycle, only oUP asserts. The down pulse is dropped, not deferred.
  - This matches the counter's up-priority.
  - oUP_LVL and oDOWN_LVL are always reported independently.
- Registered outputs: oUP and oDOWN are registered, are never high for 2 consecutive cycles from a single qualification, and are never both high.
- Counter wrap: counters saturate or clear as described above and never wrap. Each counter is sized to hold its parameter value - 1.

Optional Feature:
- Macro: KEY_AUTO_REPEAT_EN.
- Defined: a separate per-key repeat timer runs while in HELD or RELEASING.
  - It starts at 0 on entry to HELD from ARMING.
  - The first repeat pulse fires when the timer reaches REPEAT_DELAY-1; the timer then reloads to 0.
  - Later repeat pulses fire every REPEAT_PERIOD cycles.
  - Reaching IDLE or reset clears the timer.
  - Up/down priority also applies to repeat pulses.
- Undefined: there is no repeat timer logic. Exactly one pulse per qualified press, however long the key is held.

Decomposition:
- Shared package key_pkg holds:
  - FSM state encodings: IDLE=2'b00, ARMING=2'b01, HELD=2'b10, RELEASING=2'b11;
  - default timing constants for 50 MHz.
- Sub-module key_channel: one synchronizer, FSM and counter(s) per key, outputs a raw pulse and a level. Instantiated twice.
- The top level adds the up-priority arbitration and output registers.

Test Plan (DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_PERIOD=5):
- Clean press: iUP low for 20 cycles → oUP high for exactly 1 cycle, 6 cycles after the falling edge. oUP_LVL rises in the same cycle and falls 6 cycles after the rising edge. oDOWN stays 0.
- Bounce: iDOWN toggles low/high every 2 cycles for 12 cycles, then stays high → no oDOWN pulse, oDOWN_LVL stays 0. A following 10-cycle low → exactly 1 pulse.
- Simultaneous press: iUP and iDOWN fall on the same edge → oUP pulses once, oDOWN never pulses, both LVL outputs = 1.
- Release glitch: a held key goes high for 2 cycles, then low again → LVL stays 1, no extra pulse.
- Reset mid-ARMING: iRESETn low at cycle 3 of the press, released while iUP is still held → first oUP pulse 6 cycles after iRESETn deassert.
- KEY_AUTO_REPEAT_EN defined, iUP held for 40 cycles → pulses at the qualification cycle t0, then t0+10, t0+15, t0+20, …, until release qualifies. Macro undefined → single pulse only.
